ultrasonido_presencia: RTL and testbench



---
 rtl/ultrasonido_presencia_pkg.sv | 25 ++
 rtl/ultrasonido_presencia_if.sv | 26 ++
 rtl/ultrasonido_presencia_tick.sv | 28 ++
 rtl/ultrasonido_presencia.sv | 201 ++++++++++++++++++++
 tb/tb_ultrasonido_presencia.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ultrasonido_presencia_pkg.sv
// Shared types and constants for the HC-SR04 presence front-end.
package ultrasonido_pkg;

    typedef enum logic [2:0] {
        WAIT_PERIOD,
        TRIG,
        WAIT_HI,
        MEASURE,
        DONE
    } us_state_t;

    // Round-trip echo time for one centimetre of range.
    localparam int SOUND_US_PER_CM = 58;

    // Echo width in microseconds; TIMEOUT_US must fit in this width.
    localparam int MEAS_W = 16;

    // Width of the optional centimetre readout.
    localparam int CM_W = 9;

    function automatic int cm_to_us(input int cm);
        return cm * SOUND_US_PER_CM;
    endfunction

endpackage

// File: rtl/ultrasonido_presencia_if.sv
// Sensor-side and result signals of ultrasonido_presencia.
// master: the ranging front-end; slave: sensor pin driver / consumer.
// Optional ULTRASONIDO_CM_EN adds dist_cm and cm_valid.
interface ultrasonido_presencia_if;
    import ultrasonido_pkg::*;

    logic              echo;
    logic              trig;
    logic              distancia;
    logic [MEAS_W-1:0] meas_us;
    logic              meas_valid;
    logic              timeout;
`ifdef ULTRASONIDO_CM_EN
    logic [CM_W-1:0]   dist_cm;
    logic              cm_valid;

    modport master (input echo, output trig, distancia, meas_us, meas_valid, timeout,
                    dist_cm, cm_valid);
    modport slave  (output echo, input trig, distancia, meas_us, meas_valid, timeout,
                    dist_cm, cm_valid);
`else
    modport master (input echo, output trig, distancia, meas_us, meas_valid, timeout);
    modport slave  (output echo, input trig, distancia, meas_us, meas_valid, timeout);
`endif

endinterface

// File: rtl/ultrasonido_presencia_tick.sv
// Free-running prescaler: one-cycle tick every DIV clocks (DIV=1 -> every cycle).
module tick_us_gen #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic reset,
    output logic o_tick
);
    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    // Count 0..DIV-1 and register the wrap as the tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= (r_cnt == LAST);
            r_cnt  <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/ultrasonido_presencia.sv
// HC-SR04 ranging front-end: periodic trigger, echo width in us, and a
// hysteretic, N-sample-confirmed presence flag (distancia).
// Optional macro ULTRASONIDO_CM_EN adds dist_cm/cm_valid (iterative /58).
module ultrasonido_presencia
    import ultrasonido_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int TRIG_US    = 10,
    parameter int PERIOD_MS  = 60,
    parameter int TIMEOUT_US = 25000,
    parameter int THRESH_CM  = 30,
    parameter int HYST_CM    = 5,
    parameter int CONFIRM    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    ultrasonido_presencia_if.master bus
);
    // CLK_HZ is divided first so the product stays inside 32 bits.
    localparam int PERIOD_CYC = (CLK_HZ / 1000) * PERIOD_MS;
    localparam int PER_W      = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
    localparam int STRK_W     = $clog2(CONFIRM + 1);

    localparam logic [PER_W-1:0]  PER_MAX   = PER_W'(PERIOD_CYC - 1);
    localparam logic [MEAS_W-1:0] TRIG_LAST = MEAS_W'(TRIG_US - 1);
    localparam logic [MEAS_W-1:0] TMO       = MEAS_W'(TIMEOUT_US);
    localparam logic [MEAS_W-1:0] TMO_LAST  = MEAS_W'(TIMEOUT_US - 1);
    localparam logic [MEAS_W-1:0] NEAR_US   = MEAS_W'(cm_to_us(THRESH_CM));
    localparam logic [MEAS_W-1:0] FAR_US    = MEAS_W'(cm_to_us(THRESH_CM + HYST_CM));
    localparam logic [STRK_W-1:0] CONF      = STRK_W'(CONFIRM);

    logic              w_tick;
    logic              r_echo_meta, r_echo_s;
    us_state_t         r_state;
    logic [PER_W-1:0]  r_per;
    logic [MEAS_W-1:0] r_cnt;
    logic [MEAS_W-1:0] r_width;
    logic [STRK_W-1:0] r_near, r_far;
    logic              r_trig, r_dist, r_meas_valid, r_timeout;
    logic [MEAS_W-1:0] r_meas_us;
    logic              w_is_near, w_is_far;
    logic [STRK_W-1:0] w_near_inc, w_far_inc;

    tick_us_gen #(.DIV(CLK_HZ / 1_000_000)) u_tick (
        .clk    (clk),
        .reset  (reset),
        .o_tick (w_tick)
    );

    // Two-flop synchronizer; nothing downstream looks at raw echo.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_echo_meta <= 1'b0;
            r_echo_s    <= 1'b0;
        end else begin
            r_echo_meta <= bus.echo;
            r_echo_s    <= r_echo_meta;
        end
    end

    // Classification of the finished width and saturating streak increments.
    always_comb begin
        w_is_near  = (r_width < NEAR_US);
        w_is_far   = (r_width >= FAR_US);
        w_near_inc = (r_near == CONF) ? CONF : STRK_W'(r_near + 1'b1);
        w_far_inc  = (r_far == CONF) ? CONF : STRK_W'(r_far + 1'b1);
    end

    // Ranging FSM with registered outputs and presence decision in DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= WAIT_PERIOD;
            r_per        <= '0;
            r_cnt        <= '0;
            r_width      <= '0;
            r_near       <= '0;
            r_far        <= '0;
            r_trig       <= 1'b0;
            r_dist       <= 1'b0;
            r_meas_us    <= '0;
            r_meas_valid <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_meas_valid <= 1'b0;
            // Period counter runs in every state and parks at its terminal value.
            if (r_per != PER_MAX) r_per <= r_per + 1'b1;
            case (r_state)
                WAIT_PERIOD: begin
                    // A lingering echo holds off the next trigger.
                    if (r_per == PER_MAX && !r_echo_s) begin
                        r_state <= TRIG;
                        r_trig  <= 1'b1;
                        r_per   <= '0;
                        r_cnt   <= '0;
                    end
                end
                TRIG: begin
                    if (w_tick) begin
                        if (r_cnt == TRIG_LAST) begin
                            r_state <= WAIT_HI;
                            r_trig  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                WAIT_HI: begin
                    // echo_s was low when TRIG was entered, so a high level here is a rise.
                    if (r_echo_s) begin
                        r_state <= MEASURE;
                        r_width <= '0;
                    end else if (w_tick) begin
                        if (r_cnt == TMO_LAST) begin
                            r_state <= DONE;
                            r_width <= TMO;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    if (!r_echo_s) begin
                        r_state <= DONE;
                    end else if (w_tick) begin
                        if (r_width == TMO_LAST) begin
                            r_state <= DONE;
                            r_width <= TMO;
                        end else begin
                            r_width <= r_width + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state      <= WAIT_PERIOD;
                    r_meas_us    <= r_width;
                    r_meas_valid <= 1'b1;
                    r_timeout    <= (r_width == TMO);
                    if (w_is_near) begin
                        r_near <= w_near_inc;
                        r_far  <= '0;
                        if (w_near_inc == CONF) r_dist <= 1'b1;
                    end else if (w_is_far) begin
                        r_far  <= w_far_inc;
                        r_near <= '0;
                        if (w_far_inc == CONF) r_dist <= 1'b0;
                    end else begin
                        r_near <= '0;
                        r_far  <= '0;
                    end
                end
                default: r_state <= WAIT_PERIOD;
            endcase
        end
    end

    assign bus.trig       = r_trig;
    assign bus.distancia  = r_dist;
    assign bus.meas_us    = r_meas_us;
    assign bus.meas_valid = r_meas_valid;
    assign bus.timeout    = r_timeout;

`ifdef ULTRASONIDO_CM_EN
    localparam logic [MEAS_W-1:0] CM_STEP = MEAS_W'(SOUND_US_PER_CM);

    logic [MEAS_W-1:0] r_rem;
    logic [CM_W-1:0]   r_q, r_cm;
    logic              r_busy, r_cm_valid;

    // One subtraction of 58 per cycle; result published in one step.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rem      <= '0;
            r_q        <= '0;
            r_cm       <= '0;
            r_busy     <= 1'b0;
            r_cm_valid <= 1'b0;
        end else begin
            r_cm_valid <= 1'b0;
            if (r_state == DONE) begin
                r_rem  <= r_width;
                r_q    <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                if (r_rem >= CM_STEP) begin
                    r_rem <= r_rem - CM_STEP;
                    if (r_q != '1) r_q <= r_q + 1'b1;
                end else begin
                    r_cm       <= r_q;
                    r_cm_valid <= 1'b1;
                    r_busy     <= 1'b0;
                end
            end
        end
    end

    assign bus.dist_cm  = r_cm;
    assign bus.cm_valid = r_cm_valid;
`endif

endmodule

// File: tb/tb_ultrasonido_presencia.sv
// Randomized bench for ultrasonido_presencia with a history-window presence model.
module tb_ultrasonido_presencia;
    import ultrasonido_pkg::*;

    localparam int NEAR_US = 290;
    localparam int FAR_US  = 406;
    localparam int TMO     = 600;
    localparam int PERIOD  = 1000;
    localparam int NCONF   = 3;
    localparam int K_PULSE = 0;
    localparam int K_NONE  = 1;
    localparam int K_STUCK = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0, n_fail = 0, n_glitch = 0;
    int   cyc = 0, prev_rise = 0;
    bit   spacing_on = 1'b0;
    logic exp_dist = 1'b0;
    int   hist[$];

    ultrasonido_presencia_if dut_if ();

    ultrasonido_presencia #(
        .CLK_HZ(1_000_000), .TRIG_US(10), .PERIOD_MS(1), .TIMEOUT_US(TMO),
        .THRESH_CM(5), .HYST_CM(2), .CONFIRM(NCONF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp, input int tol = 0);
        n_chk++;
        if (got < exp - tol || got > exp + tol) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
        end
    endtask

    // Advance to the next falling edge; distancia may only move with meas_valid.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (!dut_if.meas_valid && dut_if.distancia !== exp_dist) n_glitch++;
    endtask

    // Presence changes only when the last NCONF readings all agree.
    task automatic model_push(input int cls);
        bit all_near, all_far;
        hist.push_back(cls);
        if (hist.size() >= NCONF) begin
            all_near = 1'b1;
            all_far  = 1'b1;
            for (int i = hist.size() - NCONF; i < hist.size(); i++) begin
                if (hist[i] != 0) all_near = 1'b0;
                if (hist[i] != 2) all_far  = 1'b0;
            end
            if (all_near) exp_dist = 1'b1;
            if (all_far)  exp_dist = 1'b0;
        end
    endtask

    // Wait for a trigger, check its spacing and width; returns at the first low sample.
    task automatic wait_trig();
        int n;
        n = 0;
        while (!dut_if.trig && n < 5000) begin tick(); n++; end
        chk("trig_seen", dut_if.trig, 1);
        if (spacing_on) chk("trig_period", cyc - prev_rise, PERIOD);
        prev_rise  = cyc;
        spacing_on = 1'b1;
        n = 0;
        while (dut_if.trig && n < 100) begin n++; tick(); end
        chk("trig_width", n, 10);
    endtask

    task automatic do_meas(input int kind, input int w);
        int n, t_fall, cls;
        wait_trig();
        t_fall = cyc;
        repeat ($urandom_range(0, 30)) tick();
        if (kind != K_NONE) dut_if.echo = 1'b1;
        if (kind == K_PULSE) begin
            repeat (w) tick();
            dut_if.echo = 1'b0;
        end
        n = 0;
        while (!dut_if.meas_valid && n < 3000) begin tick(); n++; end
        chk("meas_valid_seen", dut_if.meas_valid, 1);
        if (kind == K_PULSE) cls = (w < NEAR_US) ? 0 : (w >= FAR_US) ? 2 : 1;
        else                 cls = 2;
        model_push(cls);
        if (kind == K_PULSE) chk("meas_us", dut_if.meas_us, w, 2);
        else                 chk("meas_us_sat", dut_if.meas_us, TMO);
        if (kind == K_NONE)  chk("timeout_latency", cyc - t_fall, TMO + 1, 3);
        chk("timeout_flag", dut_if.timeout, (kind == K_PULSE) ? 0 : 1);
        chk("distancia", dut_if.distancia, exp_dist);
        tick();
        chk("meas_valid_pulse", dut_if.meas_valid, 0);
        if (kind == K_STUCK) begin
            n = 0;
            repeat (800) begin tick(); if (dut_if.trig) n++; end
            chk("trig_held_by_echo", n, 0);
            dut_if.echo = 1'b0;
            n = 0;
            while (!dut_if.trig && n < 20) begin tick(); n++; end
            chk("trig_after_echo_low", n, 3, 1);
            spacing_on = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        reset = 1'b0;
        dut_if.echo = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig", dut_if.trig, 0);
        chk("rst_distancia", dut_if.distancia, 0);
        chk("rst_meas_us", dut_if.meas_us, 0);
        chk("rst_meas_valid", dut_if.meas_valid, 0);
        chk("rst_timeout", dut_if.timeout, 0);
        reset = 1'b1;
        cyc = 0; prev_rise = 0; spacing_on = 1'b1;

        do_meas(K_NONE, 0);
        repeat (3) do_meas(K_PULSE, 200);
        chk("dist_after_3_near", dut_if.distancia, 1);
        repeat (5) do_meas(K_PULSE, 350);
        chk("dist_in_band", dut_if.distancia, 1);
        repeat (3) do_meas(K_PULSE, 450);
        chk("dist_released", dut_if.distancia, 0);

        do_meas(K_PULSE, 200); do_meas(K_PULSE, 200); do_meas(K_PULSE, 450);
        do_meas(K_PULSE, 200); do_meas(K_PULSE, 200);
        chk("dist_streak_break", dut_if.distancia, 0);

        repeat (12) begin
            r = $urandom_range(0, 9);
            if (r == 0)     do_meas(K_NONE, 0);
            else if (r < 5) do_meas(K_PULSE, $urandom_range(20, 285));
            else if (r < 7) do_meas(K_PULSE, $urandom_range(295, 400));
            else            do_meas(K_PULSE, $urandom_range(412, 590));
        end

        do_meas(K_STUCK, 0);
        repeat (3) do_meas(K_PULSE, 150);
        chk("dist_before_reset", dut_if.distancia, 1);

        // Async reset in the middle of a measurement.
        wait_trig();
        repeat (5) tick();
        dut_if.echo = 1'b1;
        repeat (60) tick();
        reset = 1'b0;
        exp_dist = 1'b0;
        #1;
        chk("rst_mid_trig", dut_if.trig, 0);
        chk("rst_mid_distancia", dut_if.distancia, 0);
        chk("rst_mid_meas_us", dut_if.meas_us, 0);
        chk("rst_mid_meas_valid", dut_if.meas_valid, 0);
        dut_if.echo = 1'b0;
        repeat (4) tick();
        hist.delete();
        reset = 1'b1;
        prev_rise = cyc; spacing_on = 1'b1;
        do_meas(K_PULSE, 200);

        chk("dist_only_with_valid", n_glitch, 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
